// File: rtl/mt_seed_init.sv
// mt_seed_init
//   Writes the MT19937 initial state into an external state memory.
//   A start request latches the seed and issues N consecutive writes at
//   addresses 0..N-1. Word 0 is the seed itself. Every later word is
//   INIT_MULT * (w ^ (w >> 30)) + index, computed modulo 2^32.
//   A one-cycle done pulse follows the last write. The machine then spends
//   one IDLE cycle before it can accept another start.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   begin a seeding run (honoured only in IDLE)
//   seed       in   [31:0] seed, captured together with an accepted start
//   seed_we    out  state-memory write strobe
//   seed_addr  out  [9:0] state-memory write address
//   seed_data  out  [31:0] state-memory write data
//   busy       out  high while writes are being issued
//   done       out  one-cycle end-of-run pulse
//
// All outputs are registered. Address and data hold their values outside WRITE.
module mt_seed_init #(
  parameter int unsigned N         = 624,
  parameter logic [31:0] INIT_MULT = 32'd1812433253
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] seed,
  output logic        seed_we,
  output logic [9:0]  seed_addr,
  output logic [31:0] seed_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [9:0] LAST_ADDR = 10'(N - 1);

  state_t      state_q, state_d;
  logic        we_d, busy_d, done_d;
  logic [9:0]  addr_d;
  logic [31:0] data_d;

  // Next word of the recurrence. It is built from the currently registered
  // word and address, so each write feeds the next one.
  logic [9:0]  addr_inc;
  logic [31:0] mixed;
  logic [31:0] next_word;

  always_comb begin
    addr_inc  = seed_addr + 10'd1;
    mixed     = seed_data ^ (seed_data >> 30);
    next_word = (INIT_MULT * mixed) + {22'd0, addr_inc};
  end

  // Next-state and next-output logic. Every output is a register, so this
  // process computes the value each one takes at the coming edge.
  always_comb begin
    state_d = state_q;
    we_d    = seed_we;
    addr_d  = seed_addr;
    data_d  = seed_data;
    busy_d  = busy;
    done_d  = done;

    case (state_q)
      IDLE: begin
        we_d   = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (start) begin
          state_d = WRITE;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = seed;
          busy_d  = 1'b1;
        end
      end

      WRITE: begin
        // start is not examined here, so a request arriving mid-run is
        // dropped rather than queued.
        if (seed_addr == LAST_ADDR) begin
          state_d = FINISH;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          addr_d = addr_inc;
          data_d = next_word;
        end
      end

      FINISH: begin
        // Always passes through IDLE, which gives back-to-back runs their
        // two-cycle gap even when start is held high.
        state_d = IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      seed_we   <= 1'b0;
      seed_addr <= '0;
      seed_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_we   <= we_d;
      seed_addr <= addr_d;
      seed_data <= data_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_mt_seed_init.sv
// tb_mt_seed_init
//   Directed bench for mt_seed_init with N=624. It checks the reset state,
//   full seeding runs for seeds 0 and 5489 against a software reference and
//   hand-derived words, and start requests that arrive mid-run or during
//   FINISH. It also covers an asynchronous abort at address 300 and start
//   held high for 2000 cycles. A background monitor checks the
//   busy/done/seed_we relationships and the address bound on every cycle.
module tb_mt_seed_init;

  localparam int unsigned N = 624;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] seed;
  logic        seed_we;
  logic [9:0]  seed_addr;
  logic [31:0] seed_data;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  mt_seed_init #(
    .N         (N),
    .INIT_MULT (32'd1812433253)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed      (seed),
    .seed_we   (seed_we),
    .seed_addr (seed_addr),
    .seed_data (seed_data),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference recurrence. The product is formed at full 64-bit width and
  // only then reduced to 32 bits.
  function automatic logic [31:0] mt_next(input logic [31:0] x, input int unsigned i);
    logic [63:0] p;
    p = 64'd1812433253 * {32'd0, x ^ {30'd0, x[31:30]}};
    return p[31:0] + i[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Invariants, checked on every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("inv_we_implies_busy", {31'd0, (!seed_we || busy)}, 32'd1);
      chk("inv_done_exclusive", {31'd0, !(done && (seed_we || busy))}, 32'd1);
      chk("inv_addr_bound", {31'd0, (seed_addr <= 10'd623)}, 32'd1);
    end
  end

  // One full run from IDLE. If inject is set, extra start requests with
  // seed 1 are issued at addresses 100/101 and during FINISH. The run must
  // ignore all of them.
  task automatic run_seq(input logic [31:0] s, input bit inject);
    logic [31:0] exp_w;
    logic [31:0] h0 [3];
    logic [31:0] h5489 [4];
    h0    = '{32'h00000000, 32'h00000001, 32'h6C078967};
    h5489 = '{32'h00001571, 32'd1301868182, 32'd2938499221, 32'd2950281878};
    // Cycle 0: present start.
    start = 1'b1;
    seed  = s;
    @(negedge clk);
    start = 1'b0;
    seed  = 32'hDEADBEEF;
    exp_w = s;
    // Cycles 1..N: one write per cycle.
    for (int unsigned k = 0; k < N; k++) begin
      chk("run_we",   {31'd0, seed_we}, 32'd1);
      chk("run_addr", {22'd0, seed_addr}, k);
      chk("run_data", seed_data, exp_w);
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("run_done", {31'd0, done}, 32'd0);
      if (s == 32'd0 && k < 3)    chk("hand_seed0", seed_data, h0[k]);
      if (s == 32'd5489 && k < 4) chk("hand_seed5489", seed_data, h5489[k]);
      if (inject && (k == 100 || k == 101)) begin
        start = 1'b1;
        seed  = 32'd1;
      end else begin
        start = 1'b0;
      end
      if (k < N - 1) exp_w = mt_next(exp_w, k + 1);
      @(negedge clk);
    end
    // Cycle N+1: FINISH with the done pulse; address and data hold.
    chk("fin_done", {31'd0, done}, 32'd1);
    chk("fin_we",   {31'd0, seed_we}, 32'd0);
    chk("fin_busy", {31'd0, busy}, 32'd0);
    chk("fin_addr", {22'd0, seed_addr}, 32'd623);
    chk("fin_data", seed_data, exp_w);
    start = inject;
    seed  = 32'd1;
    @(negedge clk);
    start = 1'b0;
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_we",   {31'd0, seed_we}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_addr", {22'd0, seed_addr}, 32'd623);
    @(negedge clk);
    chk("post_we",   {31'd0, seed_we}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int          done_cnt;
    int          gap;
    int          run_len;
    int          runs;
    bit          prev_we;
    bit          got;
    logic [31:0] exp_w;

    rst   = 1'b1;
    start = 1'b0;
    seed  = '0;
    repeat (2) @(negedge clk);
    chk("rst_we",   {31'd0, seed_we}, 32'd0);
    chk("rst_addr", {22'd0, seed_addr}, 32'd0);
    chk("rst_data", seed_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    // start while in reset is ignored.
    start = 1'b1;
    seed  = 32'd7;
    @(negedge clk);
    chk("rst_start_we", {31'd0, seed_we}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    chk("post_rst_we",   {31'd0, seed_we}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    run_seq(32'd0, 1'b0);
    run_seq(32'd5489, 1'b0);
    run_seq(32'd5489, 1'b1);

    // Asynchronous abort at address 300.
    start = 1'b1;
    seed  = 32'd5489;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_pre_addr", {22'd0, seed_addr}, 32'd300);
    chk("abort_pre_we",   {31'd0, seed_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_we",   {31'd0, seed_we}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_addr", {22'd0, seed_addr}, 32'd0);
    chk("abort_data", seed_data, 32'd0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_hold_we", {31'd0, seed_we}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    done_cnt = 0;
    run_len  = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (done)    done_cnt++;
      if (seed_we) run_len++;
    end
    chk("abort_no_done",  done_cnt, 32'd0);
    chk("abort_no_write", run_len, 32'd0);
    run_seq(32'd0, 1'b0);

    // start held high: successive runs with a two-cycle gap between them.
    start    = 1'b1;
    seed     = 32'd0;
    done_cnt = 0;
    gap      = 0;
    run_len  = 0;
    runs     = 0;
    prev_we  = 1'b0;
    exp_w    = '0;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      if (seed_we) begin
        if (!prev_we) begin
          if (runs > 0) chk("held_gap", gap, 32'd2);
          else          chk("held_first_cycle", cyc, 32'd1);
          runs++;
          run_len = 0;
          exp_w   = '0;
        end
        chk("held_addr", {22'd0, seed_addr}, run_len);
        chk("held_data", seed_data, exp_w);
        run_len++;
        exp_w = mt_next(exp_w, run_len);
        gap   = 0;
      end else begin
        gap++;
      end
      if (done) begin
        chk("held_run_len", run_len, 32'd624);
        done_cnt++;
      end
      prev_we = seed_we;
    end
    chk("held_done_count", done_cnt, 32'd3);
    chk("held_run_count", runs, 32'd4);

    // Let the partial run drain, with a bounded wait.
    start = 1'b0;
    got   = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("drain_done_seen", {31'd0, got}, 32'd1);
    @(negedge clk);
    chk("drain_idle_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
